// File: rtl/ap_fifo_elastic_stage.sv
// Elastic FIFO stage between an upstream FWFT source and a downstream write port.
// It also keeps a running beat count and an XOR checksum of everything forwarded.
module ap_fifo_elastic_stage #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [DATA_W-1:0]        in_dout,
  input  logic                     in_empty_n,
  output logic                     in_read,
  output logic [DATA_W-1:0]        out_din,
  input  logic                     out_full_n,
  output logic                     out_write,
  input  logic                     en,
  input  logic                     cnt_clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         beat_cnt,
  output logic [DATA_W-1:0]        chk
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic [1:0]        rst_sync_q;
  logic              run;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              push, pop;

  // Assertion is immediate; release takes two edges so no read lands near the reset edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];

  always_comb begin
    pop  = run & (level_q != '0) & out_full_n;
    push = run & in_empty_n & en & ((level_q != LvlW'(DEPTH)) | pop);
  end

  assign in_read   = push;
  assign out_write = pop;
  assign out_din   = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign beat_cnt  = beat_cnt_q;
  assign chk       = chk_q;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    chk_d      = chk_q;
    if (cnt_clr) begin
      beat_cnt_d = '0;
      chk_d      = '0;
    end else if (pop) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
      chk_d      = chk_q ^ out_din;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      beat_cnt_q <= '0;
      chk_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q    <= level_d;
      beat_cnt_q <= beat_cnt_d;
      chk_q      <= chk_d;
    end
  end

  // Storage needs no reset: the level count alone decides what is valid.
  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q] <= in_dout;
  end

endmodule

// File: tb/tb_ap_fifo_elastic_stage.sv
// Scoreboard bench for ap_fifo_elastic_stage: words are queued as expected when issued
// and a negedge monitor checks order, handshakes, level, beat count and checksum.
module tb_ap_fifo_elastic_stage;
  localparam int DW = 128;
  localparam int D  = 4;
  localparam int CW = 32;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [DW-1:0] in_dout;
  logic          in_empty_n, in_read;
  logic [DW-1:0] out_din;
  logic          out_full_n, out_write, en, cnt_clr;
  logic [2:0]    level;
  logic [CW-1:0] beat_cnt;
  logic [DW-1:0] chk;

  ap_fifo_elastic_stage #(.DATA_W(DW), .DEPTH(D), .CNT_W(CW)) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_dout    (in_dout),
    .in_empty_n (in_empty_n),
    .in_read    (in_read),
    .out_din    (out_din),
    .out_full_n (out_full_n),
    .out_write  (out_write),
    .en         (en),
    .cnt_clr    (cnt_clr),
    .level      (level),
    .beat_cnt   (beat_cnt),
    .chk        (chk)
  );

  always #5 ap_clk = ~ap_clk;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] src[$];
  logic [DW-1:0] expq[$];
  int            m_lvl = 0, max_lvl = 0, n_rd = 0, n_wr = 0, rel = 0;
  logic [CW-1:0] m_cnt = '0;
  logic [DW-1:0] m_chk = '0;
  logic          ew, er;
  logic [DW-1:0] w;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the two-edge reset release.
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rel <= 0;
    else if (rel < 2) rel <= rel + 1;
  end

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      check("rst in_read", in_read, 0);
      check("rst out_write", out_write, 0);
      check("rst level", level, 0);
      check("rst beat_cnt", beat_cnt, 0);
      check("rst chk", chk, 0);
      m_lvl = 0;
      m_cnt = '0;
      m_chk = '0;
    end else begin
      ew = (rel >= 2) && (m_lvl != 0) && out_full_n;
      er = (rel >= 2) && in_empty_n && en && ((m_lvl != D) || ew);
      check("out_write", out_write, ew);
      check("in_read", in_read, er);
      check("level", level, m_lvl);
      check("beat_cnt", beat_cnt, m_cnt);
      check("chk", chk, m_chk);
      if (out_write) begin
        n_wr++;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_din: got 0x%0h expected no write (scoreboard empty)", out_din);
        end else begin
          w = expq.pop_front();
          check("out_din", out_din, w);
          m_cnt = m_cnt + 1;
          m_chk = m_chk ^ w;
        end
      end
      if (cnt_clr) begin
        m_cnt = '0;
        m_chk = '0;
      end
      if (in_read) n_rd++;
      m_lvl = m_lvl + int'(in_read) - int'(out_write);
      if (m_lvl > max_lvl) max_lvl = m_lvl;
    end
  end

  task automatic drive();
    in_empty_n = (src.size() > 0);
    in_dout    = (src.size() > 0) ? src[0] : '0;
  endtask

  task automatic feed(input logic [DW-1:0] wd);
    src.push_back(wd);
    expq.push_back(wd);
    drive();
  endtask

  task automatic step();
    logic rd;
    @(negedge ap_clk);
    rd = in_read;
    @(posedge ap_clk);
    #1;
    if (rd && src.size() > 0) void'(src.pop_front());
    drive();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (expq.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check(name, expq.size(), 0);
  endtask

  initial begin
    en = 1'b1;
    out_full_n = 1'b1;
    cnt_clr = 1'b0;
    drive();
    repeat (3) step();
    ap_rst_n = 1'b1;
    repeat (3) step();

    // Streaming 0x1..0x10 with an always-ready sink.
    n_wr = 0;
    max_lvl = 0;
    for (int i = 1; i <= 16; i++) feed(DW'(i));
    drain("t1 drained", 60);
    check("t1 writes", n_wr, 16);
    check("t1 beat_cnt", beat_cnt, 16);
    check("t1 chk", chk, 'h10);
    check("t1 max level", max_lvl, 1);

    // Blocked sink: only DEPTH words may be taken.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    out_full_n = 1'b0;
    n_rd = 0;
    for (int i = 1; i <= 6; i++) feed(DW'(i));
    repeat (10) step();
    check("t2 reads", n_rd, 4);
    check("t2 level", level, 4);
    out_full_n = 1'b1;
    drain("t2 drained", 40);

    // Full buffer with simultaneous push and pop.
    out_full_n = 1'b0;
    for (int i = 0; i < 30; i++) feed(DW'('h100 + i));
    repeat (6) step();
    check("t3 level full", level, 4);
    out_full_n = 1'b1;
    begin
      int bad = 0;
      repeat (20) begin
        step();
        if (level != 3'd4) bad++;
      end
      check("t3 level held", bad, 0);
    end
    drain("t3 drained", 60);

    // en=0 stops reads but buffered words still drain.
    out_full_n = 1'b0;
    for (int i = 1; i <= 3; i++) feed(DW'('h200 + i));
    repeat (5) step();
    check("t4 level", level, 3);
    en = 1'b0;
    feed(DW'('h204));
    feed(DW'('h205));
    n_rd = 0;
    n_wr = 0;
    out_full_n = 1'b1;
    repeat (6) step();
    check("t4 reads", n_rd, 0);
    check("t4 writes", n_wr, 3);
    check("t4 level", level, 0);
    en = 1'b1;
    drain("t4 drained", 20);

    // Clear on the same cycle as a write.
    out_full_n = 1'b0;
    feed(DW'('h5a5a));
    repeat (3) step();
    check("t5 level", level, 1);
    cnt_clr = 1'b1;
    out_full_n = 1'b1;
    #1;
    check("t5 out_write", out_write, 1);
    step();
    cnt_clr = 1'b0;
    check("t5 beat_cnt", beat_cnt, 0);
    check("t5 chk", chk, 0);

    // Reset with words buffered, then a fresh word after release.
    out_full_n = 1'b0;
    for (int i = 1; i <= 3; i++) feed(DW'('h300 + i));
    repeat (5) step();
    check("t6 level", level, 3);
    check("t6 beat_cnt pre", beat_cnt, 0);
    ap_rst_n = 1'b0;
    #1;
    check("t6 rst in_read", in_read, 0);
    check("t6 rst out_write", out_write, 0);
    check("t6 rst level", level, 0);
    src.delete();
    expq.delete();
    drive();
    repeat (2) step();
    ap_rst_n = 1'b1;
    out_full_n = 1'b1;
    feed(DW'('haa));
    begin
      int n = 0;
      while (!out_write && n < 10) begin
        step();
        n++;
      end
    end
    check("t6 first out_write", out_write, 1);
    check("t6 first out_din", out_din, 'haa);
    drain("t6 drained", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
